// File: rtl/sram_arbiter.sv
// Arbitrates instruction and data requests onto one single-port SRAM, one access in flight.
// Define ARB_RR_EN for round-robin on conflicts; the default build gives data fixed priority.
module sram_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ok,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ok,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stallreq
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;      // 1 = data side owns the access
    logic        mem_en_q, mem_en_d;
    logic [3:0]  mem_wen_q, mem_wen_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        grant_data;

`ifdef ARB_RR_EN
    logic        last_grant_q, last_grant_d;   // 1 = data was granted last
    assign grant_data = data_req & (~inst_req | ~last_grant_q);
`else
    assign grant_data = data_req;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        mem_en_d     = 1'b0;
        mem_wen_d    = 4'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (inst_req | data_req) begin
                    state_d     = ISSUE;
                    owner_d     = grant_data;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = grant_data ? data_addr  : inst_addr;
                    mem_wen_d   = grant_data ? data_wen   : 4'b0;
                    mem_wdata_d = grant_data ? data_wdata : 32'b0;
`ifdef ARB_RR_EN
                    last_grant_d = grant_data;
`endif
                end
            end
            ISSUE: begin
                // The latched enables are still visible here, so they tell read from write.
                if (mem_wen_q != 4'b0) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_INIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RESP;
                    if (owner_q) data_rdata_d = mem_rdata;
                    else         inst_rdata_d = mem_rdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'b0;
            owner_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wen_q    <= 4'b0;
            mem_addr_q   <= 32'b0;
            mem_wdata_q  <= 32'b0;
            inst_rdata_q <= 32'b0;
            data_rdata_q <= 32'b0;
`ifdef ARB_RR_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            mem_en_q     <= mem_en_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
`ifdef ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign inst_ok    = (state_q == RESP) & ~owner_q;
    assign data_ok    = (state_q == RESP) &  owner_q;
    assign stallreq   = (inst_req & ~inst_ok) | (data_req & ~data_ok);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (MEM_LAT 1 and 3), each with its own SRAM model,
// requester and a timestamp-based transaction model checked every cycle.
module tb_sram_arbiter;

    int   checks = 0;
    int   errors = 0;
    logic clk = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input int lat, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lat%0d %s: got %h, expected %h", lat, nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int k, input int i);
        if (i == 0) return 32'h3C1D0001;
        return (32'(i) * 32'h9E3779B9) ^ (32'(k + 1) * 32'h01000193);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] wen);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (wen[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    for (genvar K = 0; K < 2; K++) begin : g
        localparam int LAT = (K == 0) ? 1 : 3;

        logic        rst = 1'b0;
        logic        inst_req, data_req, inst_ok, data_ok, mem_en, stallreq;
        logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
        logic [31:0] mem_addr, mem_wdata, mem_rdata;
        logic [3:0]  data_wen, mem_wen;
        bit          done = 1'b0;

        sram_arbiter #(.MEM_LAT(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
            .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
            .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ok(data_ok),
            .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata), .stallreq(stallreq)
        );

        // SRAM: read data appears LAT cycles after the enable cycle, garbage otherwise
        logic [31:0] mem [16];
        logic [31:0] pd [4];
        logic [3:0]  pv;
        logic [31:0] garb;
        assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : garb;

        initial begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(K, i);
            pv   <= 4'b0;
            garb <= 32'hDEADBEEF;
            forever begin
                @(posedge clk);
                garb <= $urandom;
                for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
                pd[0] <= mem[mem_addr[5:2]];
                pv    <= {pv[2:0], mem_en && (mem_wen == 4'b0)};
                if (mem_en && mem_wen != 4'b0)
                    mem[mem_addr[5:2]] <= merge(mem[mem_addr[5:2]], mem_wdata, mem_wen);
            end
        end

        // Transaction model: a grant seen at cycle c issues at c+1 and completes
        // 1 (write) or LAT+1 (read) cycles later; IDLE samples again the cycle after.
        int          cyc, issue_c, ok_c, idle_c;
        bit          tx_act, tx_data, tx_wr, last_data, e_en, e_iok, e_dok;
        logic [31:0] tx_addr, tx_wdata, tx_rdata, m_ird, m_drd;
        logic [3:0]  tx_wen;
        logic [31:0] ref_mem [16];

        initial begin
            for (int i = 0; i < 16; i++) ref_mem[i] = init_word(K, i);
            cyc = 0; tx_act = 0; idle_c = 0; last_data = 0; m_ird = 0; m_drd = 0;
            issue_c = 0; ok_c = 0;
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst) begin
                    tx_act = 0; idle_c = cyc; last_data = 0; m_ird = 0; m_drd = 0;
                    chk(LAT, "reset ctl", {25'b0, mem_en, mem_wen, inst_ok, data_ok}, 32'h0);
                    chk(LAT, "reset mem_addr", mem_addr, 32'h0);
                    chk(LAT, "reset mem_wdata", mem_wdata, 32'h0);
                    chk(LAT, "reset inst_rdata", inst_rdata, 32'h0);
                    chk(LAT, "reset data_rdata", data_rdata, 32'h0);
                    chk(LAT, "reset stallreq", 32'(stallreq), 32'(inst_req | data_req));
                end else begin
                    e_en  = tx_act && cyc == issue_c;
                    e_iok = tx_act && cyc == ok_c && !tx_data;
                    e_dok = tx_act && cyc == ok_c &&  tx_data;
                    if (tx_act && cyc == ok_c && !tx_wr) begin
                        if (tx_data) m_drd = tx_rdata;
                        else         m_ird = tx_rdata;
                    end
                    chk(LAT, "mem_en", 32'(mem_en), 32'(e_en));
                    if (e_en) begin
                        chk(LAT, "mem_addr", mem_addr, tx_addr);
                        chk(LAT, "mem_wen", 32'(mem_wen), 32'(tx_wen));
                        if (tx_wr) begin
                            chk(LAT, "mem_wdata", mem_wdata, tx_wdata);
                            ref_mem[tx_addr[5:2]] = merge(ref_mem[tx_addr[5:2]], tx_wdata, tx_wen);
                        end
                    end else begin
                        chk(LAT, "idle mem_wen", 32'(mem_wen), 32'h0);
                    end
                    chk(LAT, "inst_ok", 32'(inst_ok), 32'(e_iok));
                    chk(LAT, "data_ok", 32'(data_ok), 32'(e_dok));
                    chk(LAT, "inst_rdata", inst_rdata, m_ird);
                    chk(LAT, "data_rdata", data_rdata, m_drd);
                    chk(LAT, "stallreq", 32'(stallreq), 32'((inst_req & ~e_iok) | (data_req & ~e_dok)));
                    if (tx_act && cyc == ok_c) tx_act = 0;
                    if (!tx_act && cyc >= idle_c && (inst_req || data_req)) begin
`ifdef ARB_RR_EN
                        tx_data = data_req && (!inst_req || !last_data);
`else
                        tx_data = data_req;
`endif
                        last_data = tx_data;
                        tx_addr   = tx_data ? data_addr : inst_addr;
                        tx_wen    = tx_data ? data_wen : 4'b0;
                        tx_wdata  = data_wdata;
                        tx_wr     = tx_wen != 4'b0;
                        tx_rdata  = ref_mem[tx_addr[5:2]];
                        issue_c   = cyc + 1;
                        ok_c      = issue_c + (tx_wr ? 1 : LAT + 1);
                        idle_c    = ok_c + 1;
                        tx_act    = 1;
                    end
                end
            end
        end

        task automatic wait_ok(input bit dside, output int lat, output int en_at, output int en_cnt);
            lat = -1; en_at = -1; en_cnt = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (mem_en) begin
                    if (en_at < 0) en_at = i;
                    en_cnt++;
                end
                if (dside ? data_ok : inst_ok) begin
                    lat = i;
                    break;
                end
            end
        endtask

        initial begin
            int   lat, en_at, en_cnt, own;
            logic io, dk;
            inst_req = 0; inst_addr = 0; data_req = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
            repeat (3) @(posedge clk);
            #1 rst = 1;

            // instruction fetch from the reset vector
            @(posedge clk); #1 inst_req = 1; inst_addr = 32'hBFC00000;
            wait_ok(0, lat, en_at, en_cnt);
            chk(LAT, "fetch latency", 32'(lat), (K == 0) ? 32'd3 : 32'd5);
            chk(LAT, "fetch mem_en cycle", 32'(en_at), 32'd1);
            chk(LAT, "fetch mem_en count", 32'(en_cnt), 32'd1);
            chk(LAT, "fetch data", inst_rdata, 32'h3C1D0001);
            @(posedge clk); #1 inst_req = 0;

            // half-word write
            @(posedge clk); #1 data_req = 1; data_addr = 32'h80001000; data_wen = 4'b0011; data_wdata = 32'h1234ABCD;
            wait_ok(1, lat, en_at, en_cnt);
            chk(LAT, "write latency", 32'(lat), 32'd2);
            chk(LAT, "write mem_en cycle", 32'(en_at), 32'd1);
            chk(LAT, "write mem_en count", 32'(en_cnt), 32'd1);
            chk(LAT, "write keeps data_rdata", data_rdata, 32'h0);
            @(posedge clk); #1 data_req = 0; data_wen = 0;

            // read back the merged word
            @(posedge clk); #1 data_req = 1; data_addr = 32'h80001000;
            wait_ok(1, lat, en_at, en_cnt);
            chk(LAT, "read latency", 32'(lat), (K == 0) ? 32'd3 : 32'd5);
            chk(LAT, "read mem_en count", 32'(en_cnt), 32'd1);
            chk(LAT, "read data", data_rdata, 32'h3C1DABCD);
            @(posedge clk); #1 data_req = 0;

            // reset while the fetch sits in WAIT
            @(posedge clk); #1 inst_req = 1; inst_addr = 32'hBFC00000;
            @(posedge clk); @(posedge clk); #1 rst = 0;
            @(negedge clk);
            chk(LAT, "abort outputs", {29'b0, inst_ok, data_ok, mem_en}, 32'h0);
            chk(LAT, "abort inst_rdata", inst_rdata, 32'h0);
            @(posedge clk); #1 rst = 1;
            wait_ok(0, lat, en_at, en_cnt);
            chk(LAT, "refetch latency", 32'(lat), (K == 0) ? 32'd3 : 32'd5);
            chk(LAT, "refetch data", inst_rdata, 32'h3C1DABCD);
            @(posedge clk); #1 inst_req = 0;

            // both sides held: grant order right after a reset
            @(posedge clk); #1 rst = 0;
            @(posedge clk); #1 rst = 1;
            inst_req = 1; inst_addr = 32'h14; data_req = 1; data_addr = 32'h28; data_wen = 0;
            for (int gi = 0; gi < 4; gi++) begin
                own = -1;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (inst_ok || data_ok) begin
                        own = data_ok ? 1 : 0;
                        break;
                    end
                end
`ifdef ARB_RR_EN
                chk(LAT, "grant order", 32'(own), (gi % 2 == 0) ? 32'd1 : 32'd0);
`else
                chk(LAT, "grant order", 32'(own), 32'd1);
`endif
            end
            @(posedge clk); #1 inst_req = 0; data_req = 0;
            repeat (2) @(posedge clk);

            // random traffic with occasional reset pulses
            for (int n = 0; n < 400; n++) begin
                @(negedge clk); io = inst_ok; dk = data_ok;
                @(posedge clk); #1;
                if (!rst) rst = 1;
                else if (n < 300 && $urandom_range(0, 99) == 0) rst = 0;
                if (!inst_req || io) begin
                    if (n < 300 && $urandom_range(0, 2) != 0) begin
                        inst_req = 1; inst_addr = $urandom;
                    end else inst_req = 0;
                end
                if (!data_req || dk) begin
                    if (n < 300 && $urandom_range(0, 2) != 0) begin
                        data_req   = 1; data_addr = $urandom; data_wdata = $urandom;
                        data_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
                    end else data_req = 0;
                end
            end
            inst_req = 0; data_req = 0; rst = 1;
            repeat (3) @(posedge clk);
            done = 1;
        end
    end

    initial begin
        wait (g[0].done && g[1].done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: MEM_LAT, default 1, memory read latency in cycles from mem_en cycle to valid mem_rdata; legal range 1..4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 inst_req  input  1  instruction read request; held high with inst_addr stable until inst_ok.
REQ-005 inst_addr  input  32  instruction byte address.
REQ-006 inst_rdata  output  32  registered instruction read data; valid while inst_ok=1.
REQ-007 inst_ok  output  1  one-cycle completion pulse for instruction request.
REQ-008 data_req  input  1  data request; held high with data_addr/data_wen/data_wdata stable until data_ok.
REQ-009 data_wen  input  4  byte write enables; 0 = read.
REQ-010 data_addr  input  32  data byte address.
REQ-011 data_wdata  input  32  write data.
REQ-012 data_rdata  output  32  registered data read data; valid while data_ok=1.
REQ-013 data_ok  output  1  one-cycle completion pulse for data request.
REQ-014 mem_en  output  1  shared single-port SRAM enable, registered, high exactly one cycle per access.
REQ-015 mem_wen  output  4  SRAM byte write enables, registered, valid with mem_en.
REQ-016 mem_addr  output  32  SRAM address, registered, valid with mem_en.
REQ-017 mem_wdata  output  32  SRAM write data, registered, valid with mem_en.
REQ-018 mem_rdata  input  32  SRAM read data.
REQ-019 stallreq  output  1  pipeline stall request to core stall controller (combinational).

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one access in flight at most.
REQ-021 IDLE: if any req high at edge, latch winner's addr/wen/wdata and owner bit, go ISSUE; else stay IDLE.
REQ-022 ISSUE: mem_en=1 with latched fields for this one cycle; writes go to RESP, reads go to WAIT with latency counter loaded to MEM_LAT.
REQ-023 WAIT: counter decrements each cycle; at count 1, capture mem_rdata into owner's rdata register, go RESP.
REQ-024 RESP: owner's ok=1 for exactly this cycle, return to IDLE; requests are not sampled in RESP (a req still high re-arbitrates in IDLE next cycle).
REQ-025 Latency req-seen-in-IDLE to ok: read = MEM_LAT+2 cycles, write = 2 cycles.
REQ-026 Non-owner's rdata/ok SHALL be unchanged/0; rdata registers hold last value between accesses.
REQ-027 Arbitration on simultaneous inst_req and data_req per REQ-036/037; last_grant bit updated on every grant.
REQ-028 stallreq = (inst_req & ~inst_ok) | (data_req & ~data_ok).
REQ-029 A req dropped before ok is illegal input; behaviour unspecified except FSM SHALL still return to IDLE via RESP.
REQ-030 mem_wen SHALL be 0 whenever mem_en=0.

Reset
REQ-031 rst low SHALL immediately force state IDLE, counter 0, last_grant=inst.
REQ-032 During reset all outputs 0: mem_en, mem_wen, mem_addr, mem_wdata, inst_ok, data_ok, inst_rdata, data_rdata; stallreq follows REQ-028.
REQ-033 Reset asserted mid-access SHALL abort it with no ok pulse; after release arbitration restarts from IDLE.
REQ-034 First grant SHALL occur no earlier than the first rising edge after rst deasserts.

Configuration
REQ-035 Macro ARB_RR_EN selects arbitration policy.
REQ-036 ARB_RR_EN defined: round-robin; on conflict grant the side not granted last (data wins first after reset).
REQ-037 ARB_RR_EN undefined: fixed priority, data always wins conflicts; last_grant unused.

Verification
REQ-038 MEM_LAT=1, inst_req=1 addr 0xBFC00000, mem_rdata=0x3C1D0001 -> mem_en at cycle 1, inst_ok with inst_rdata=0x3C1D0001 at cycle 3, stallreq high cycles 0-2.
REQ-039 data write addr 0x80001000, wen 4'b0011, wdata 0x1234ABCD -> mem_en=1 one cycle with those fields, data_ok next cycle, data_rdata unchanged.
REQ-040 Both reqs held high, ARB_RR_EN defined -> grant order data, inst, data, inst; undefined -> data continuously, inst_ok never while data_req held.
REQ-041 MEM_LAT=3 read -> data_ok exactly 5 cycles after request seen in IDLE, mem_en single-cycle.
REQ-042 rst low during WAIT -> no ok pulse, all outputs 0; after release, held req completes with correct data.
